// File: rtl/shift_seq_ctrl_pkg.sv
// shift_seq_pkg: state encoding, shifter mode codes and default widths
// shared by the multi-step shift sequencer and its neighbours.
package shift_seq_pkg;

  localparam int SEQ_WIDTH = 4;
  localparam int SEQ_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SAR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_INV  = 3'b111;

  function automatic logic is_busy(
    input seq_state_e s
  );
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command and result handshakes of the shift sequencer.
// slave = sequencer side, master = producer/consumer side.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = shift_seq_pkg::SEQ_WIDTH,
  parameter int CNT_W = shift_seq_pkg::SEQ_CNT_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [2:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_data,
    input  cmd_mode,
    input  cmd_count,
    output res_valid,
    input  res_ready,
    output res_data
  );

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_data,
    output cmd_mode,
    output cmd_count,
    input  res_valid,
    output res_ready,
    input  res_data
  );

endinterface

// File: rtl/shift_seq_ctrl.sv
// Iterates an external shifter N times on one operand, feeding r back to a.
// Optional abort input enabled by SHIFT_SEQ_ABORT_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  shift_seq_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] sh_a,
  output logic [2:0]       sh_mode,
  input  logic [WIDTH-1:0] sh_r,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic st_idle;
  logic st_run;
  logic st_done;
  logic do_abort;

  assign st_idle = state_q == ST_IDLE;
  assign st_run  = state_q == ST_RUN;
  assign st_done = state_q == ST_DONE;

`ifdef SHIFT_SEQ_ABORT_EN
  assign do_abort = abort & ~st_idle;
`else
  assign do_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      st_idle: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_data;
          mode_d = bus.cmd_mode;
          cnt_d  = bus.cmd_count;
          if (bus.cmd_count == '0)
            state_d = ST_DONE;
          else
            state_d = ST_RUN;
        end
      end
      st_run: begin
        op_d  = sh_r;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_d = ST_DONE;
      end
      st_done: begin
        if (bus.res_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // abort wins over any RUN/DONE progress
    if (do_abort) begin
      state_d = ST_IDLE;
      op_d    = '0;
      cnt_d   = '0;
    end
  end

  assign bus.cmd_ready = st_idle;
  assign bus.res_valid = st_done;
  assign bus.res_data  = op_q;
  assign sh_a          = op_q;
  assign sh_mode       = mode_q;
  assign busy          = is_busy(state_q);

endmodule
